// File: rtl/fsm_pkg.sv
// Shared definitions for the serial sequence detector: output-mode constants
// and the elaboration-time helpers that build the KMP transition table.
package fsm_pkg;

    localparam bit MODE_MEALY = 1'b1;
    localparam bit MODE_MOORE = 1'b0;

    // Length of the longest proper prefix of the pattern that is also a suffix
    // of the whole pattern. This is where matching resumes after an
    // overlapping hit.
    function automatic int fail_len(input int pattern, input int width);
        for (int k = width - 1; k >= 1; k--) begin
            if ((pattern & ((1 << k) - 1)) == (pattern >> (width - k))) begin
                return k;
            end
        end
        return 0;
    endfunction

    // Longest pattern prefix that is a suffix of (prefix of length s, then b).
    // A return value equal to width means the whole pattern was just seen.
    // Out-of-range states map to 0 so padded table rows are harmless.
    function automatic int next_state(input int pattern, input int width,
                                      input int s, input int b);
        int str;
        if (s < 0 || s >= width) begin
            return 0;
        end
        str = ((pattern >> (width - s)) << 1) | (b & 1);
        for (int k = s + 1; k >= 1; k--) begin
            if ((str & ((1 << k) - 1)) == (pattern >> (width - k))) begin
                return k;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/seq_detect_fsm_if.sv
// Serial stream and result signals between a front end and the detector.
interface seq_detect_fsm_if #(
    parameter int COUNT_W = 8,
    parameter int STATE_W = 3
);
    logic               clr;
    logic               din_valid;
    logic               din;
    logic               dout;
    logic [COUNT_W-1:0] match_count;
    logic [STATE_W-1:0] state_o;

    modport master (
        output clr, din_valid, din,
        input  dout, match_count, state_o
    );

    modport slave (
        input  clr, din_valid, din,
        output dout, match_count, state_o
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, async active-low reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Clear wins over increment; increment stops at the maximum value
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector. The state is the length of the pattern prefix
// currently matched; transitions come from a KMP table built at elaboration.
module seq_detect_fsm
    import fsm_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter bit                   MEALY     = 1'b1,
    parameter int                   COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_fsm_if.slave    bus
);

    localparam int STATE_W     = $clog2(PATTERN_W + 1);
    localparam int NUM_ROWS    = 1 << STATE_W;
    localparam int PATTERN_INT = int'(PATTERN);
    localparam int FAIL_LEN    = fail_len(PATTERN_INT, PATTERN_W);
    localparam bit IS_MEALY    = (MEALY == MODE_MEALY);

    // Table is padded to a power of two so the state register indexes it
    // directly; padded rows fall back to S0 and are never reached.
    logic [STATE_W-1:0] next_tbl  [NUM_ROWS][2];
    logic               match_tbl [NUM_ROWS][2];

    genvar gi;
    genvar gb;
    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            for (gb = 0; gb < 2; gb++) begin : g_bit
                localparam int K    = next_state(PATTERN_INT, PATTERN_W, gi, gb);
                localparam bit HIT  = (K == PATTERN_W);
                localparam int DEST = HIT ? (OVERLAP ? FAIL_LEN : 0) : K;
                assign next_tbl[gi][gb]  = STATE_W'(DEST);
                assign match_tbl[gi][gb] = HIT;
            end
        end
    endgenerate

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               moore_q;
    logic               moore_d;
    logic               match;

    // State register and registered Moore flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            moore_q <= 1'b0;
        end else begin
            state_q <= state_d;
            moore_q <= moore_d;
        end
    end

    // Next state and match detection; clear suppresses any same-cycle match
    always_comb begin
        state_d = state_q;
        match   = 1'b0;
        if (bus.clr) begin
            state_d = '0;
        end else if (bus.din_valid) begin
            state_d = next_tbl[state_q][bus.din];
            match   = match_tbl[state_q][bus.din];
        end
        // The Moore flag follows the match, so it drops after one cycle
        moore_d = match;
    end

    // Output drive: combinational match in Mealy mode, registered flag in Moore mode
    always_comb begin
        bus.dout    = IS_MEALY ? match : moore_q;
        bus.state_o = state_q;
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr),
        .inc   (match),
        .count (bus.match_count)
    );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: five instances with different parameters share
// one input stream and are compared against a history-based reference model.
module tb_seq_detect_fsm;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic din_valid = 1'b0;
    logic din = 1'b0;

    always #5 clk = ~clk;

    // a: 1011 ovl mealy | b: 1011 no-ovl mealy | c: 1011 ovl moore
    // d: 1011 ovl mealy, 2-bit counter | e: 11011 no-ovl moore
    seq_detect_fsm_if #(.COUNT_W(8), .STATE_W(3)) if_a ();
    seq_detect_fsm_if #(.COUNT_W(8), .STATE_W(3)) if_b ();
    seq_detect_fsm_if #(.COUNT_W(8), .STATE_W(3)) if_c ();
    seq_detect_fsm_if #(.COUNT_W(2), .STATE_W(3)) if_d ();
    seq_detect_fsm_if #(.COUNT_W(8), .STATE_W(3)) if_e ();

    assign if_a.clr = clr; assign if_a.din_valid = din_valid; assign if_a.din = din;
    assign if_b.clr = clr; assign if_b.din_valid = din_valid; assign if_b.din = din;
    assign if_c.clr = clr; assign if_c.din_valid = din_valid; assign if_c.din = din;
    assign if_d.clr = clr; assign if_d.din_valid = din_valid; assign if_d.din = din;
    assign if_e.clr = clr; assign if_e.din_valid = din_valid; assign if_e.din = din;

    seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .COUNT_W(8))
        u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b1), .COUNT_W(8))
        u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .COUNT_W(8))
        u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .COUNT_W(2))
        u_d (.clk(clk), .rst(rst), .bus(if_d.slave));
    seq_detect_fsm #(.PATTERN_W(5), .PATTERN(5'b11011), .OVERLAP(1'b0), .MEALY(1'b0), .COUNT_W(8))
        u_e (.clk(clk), .rst(rst), .bus(if_e.slave));

    int obs_st   [N];
    int obs_dout [N];
    int obs_cnt  [N];

    always_comb begin
        obs_st[0] = int'(if_a.state_o); obs_dout[0] = int'(if_a.dout); obs_cnt[0] = int'(if_a.match_count);
        obs_st[1] = int'(if_b.state_o); obs_dout[1] = int'(if_b.dout); obs_cnt[1] = int'(if_b.match_count);
        obs_st[2] = int'(if_c.state_o); obs_dout[2] = int'(if_c.dout); obs_cnt[2] = int'(if_c.match_count);
        obs_st[3] = int'(if_d.state_o); obs_dout[3] = int'(if_d.dout); obs_cnt[3] = int'(if_d.match_count);
        obs_st[4] = int'(if_e.state_o); obs_dout[4] = int'(if_e.dout); obs_cnt[4] = int'(if_e.match_count);
    end

    // Reference model parameters per instance
    int m_pat [N] = '{11, 11, 11, 11, 27};
    int m_w   [N] = '{4, 4, 4, 4, 5};
    int m_ovl [N] = '{1, 0, 1, 1, 0};
    int m_mly [N] = '{1, 1, 0, 1, 0};
    int m_cw  [N] = '{8, 8, 8, 2, 8};

    // Reference model state: accepted bits since the last restart
    int hist [N];
    int hlen [N];
    int cnt  [N];
    int mq   [N];

    int n_pass  = 0;
    int n_total = 0;

    function automatic int msk(input int k);
        return (1 << k) - 1;
    endfunction

    // Longest pattern prefix (shorter than the pattern) ending the history
    function automatic int model_state(input int i);
        for (int k = m_w[i] - 1; k >= 1; k--) begin
            if (hlen[i] >= k && ((hist[i] & msk(k)) == (m_pat[i] >> (m_w[i] - k))))
                return k;
        end
        return 0;
    endfunction

    // Would the presented bit complete the pattern at the end of the history?
    function automatic int model_match(input int i, input int v, input int d, input int c);
        int h2;
        if (v == 0 || c != 0) return 0;
        h2 = (hist[i] << 1) | d;
        if (hlen[i] + 1 >= m_w[i] && ((h2 & msk(m_w[i])) == m_pat[i])) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hist[i] = 0; hlen[i] = 0; cnt[i] = 0; mq[i] = 0;
        end
    endtask

    task automatic model_step(input int v, input int d, input int c);
        int m;
        for (int i = 0; i < N; i++) begin
            if (c != 0) begin
                hist[i] = 0; hlen[i] = 0; cnt[i] = 0; mq[i] = 0;
            end else begin
                m = model_match(i, v, d, c);
                mq[i] = m;
                if (v != 0) begin
                    hist[i] = ((hist[i] << 1) | d) & 16'hFFFF;
                    hlen[i] = (hlen[i] < 16) ? hlen[i] + 1 : 16;
                    if (m != 0) begin
                        if (cnt[i] < msk(m_cw[i])) cnt[i] = cnt[i] + 1;
                        if (m_ovl[i] == 0) begin
                            hist[i] = 0; hlen[i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock: drive at the falling edge, compare pre-edge outputs, advance model
    task automatic cycle(input int v, input int d, input int c);
        int exp_dout;
        @(negedge clk);
        din_valid = v[0];
        din       = d[0];
        clr       = c[0];
        #1;
        for (int i = 0; i < N; i++) begin
            exp_dout = (m_mly[i] != 0) ? model_match(i, v, d, c) : mq[i];
            chk($sformatf("u%0d state", i), obs_st[i], model_state(i));
            chk($sformatf("u%0d dout", i), obs_dout[i], exp_dout);
            chk($sformatf("u%0d count", i), obs_cnt[i], cnt[i]);
        end
        if (rst) model_step(v, d, c);
    endtask

    typedef struct {
        int v; int d; int c;
        int st_a; int dout_a; int cnt_a;
        int st_b; int dout_b; int cnt_b;
        int dout_c;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stream 1011011 then two idle cycles; expected pre-edge values
        tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 2, 0, 0, 2, 0, 0, 0};
        tbl[3] = '{1, 1, 0, 3, 1, 0, 3, 1, 0, 0};
        tbl[4] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1};
        tbl[5] = '{1, 1, 0, 2, 0, 1, 0, 0, 1, 0};
        tbl[6] = '{1, 1, 0, 3, 1, 1, 1, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 1, 0, 2, 1, 0, 1, 1};
        tbl[8] = '{0, 0, 0, 1, 0, 2, 1, 0, 1, 0};

        model_reset();

        // Reset held for 400 ns with the input toggling
        for (int t = 0; t < 40; t++) begin
            cycle(1, t % 2, 0);
            chk("reset state", obs_st[0], 0);
            chk("reset dout", obs_dout[2], 0);
        end
        @(negedge clk);
        din_valid = 1'b0;
        rst       = 1'b1;

        // Directed stream through all instances
        cycle(0, 0, 1);
        for (int r = 0; r < 9; r++) begin
            cycle(tbl[r].v, tbl[r].d, tbl[r].c);
            chk($sformatf("tbl%0d a state", r), obs_st[0], tbl[r].st_a);
            chk($sformatf("tbl%0d a dout", r), obs_dout[0], tbl[r].dout_a);
            chk($sformatf("tbl%0d a count", r), obs_cnt[0], tbl[r].cnt_a);
            chk($sformatf("tbl%0d b state", r), obs_st[1], tbl[r].st_b);
            chk($sformatf("tbl%0d b dout", r), obs_dout[1], tbl[r].dout_b);
            chk($sformatf("tbl%0d b count", r), obs_cnt[1], tbl[r].cnt_b);
            chk($sformatf("tbl%0d c dout", r), obs_dout[2], tbl[r].dout_c);
        end

        // Bubbles inside the pattern: 10, three idle cycles, 11
        cycle(0, 0, 1);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        for (int t = 0; t < 3; t++) begin
            cycle(0, 1, 0);
            chk("bubble state", obs_st[0], 2);
        end
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("bubble dout", obs_dout[0], 1);
        cycle(0, 0, 0);
        chk("bubble count", obs_cnt[0], 1);

        // Five overlapping matches saturate the 2-bit counter
        cycle(0, 0, 1);
        for (int m = 0; m < 5; m++) begin
            cycle(1, 1, 0); cycle(1, 0, 0); cycle(1, 1, 0); cycle(1, 1, 0);
        end
        cycle(0, 0, 0);
        chk("sat count d", obs_cnt[3], 3);
        chk("sat count a", obs_cnt[0], 5);

        // Clear in the same cycle as the final bit
        cycle(1, 1, 0); cycle(1, 0, 0); cycle(1, 1, 0);
        cycle(1, 1, 1);
        chk("clr dout", obs_dout[0], 0);
        cycle(0, 0, 0);
        chk("clr count", obs_cnt[0], 0);
        chk("clr state", obs_st[0], 0);
        chk("clr moore", obs_dout[2], 0);

        // Asynchronous reset after 101, checked before any clock edge
        cycle(1, 1, 0); cycle(1, 0, 0); cycle(1, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst state", obs_st[0], 0);
        chk("async rst count", obs_cnt[1], 0);
        model_reset();
        @(negedge clk);
        din_valid = 1'b0;
        rst       = 1'b1;

        // Randomised traffic against the model
        for (int t = 0; t < 3000; t++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_detect_fsm.md
# seq_detect_fsm

Parametrised serial sequence detector: scans a 1-bit input stream for a configurable pattern and flags each occurrence. Output mode (Mealy or Moore) and overlap handling are selected by parameter. A saturating match counter is included. Sits behind any serial front end (UART RX bit stream, GPIO sampler) as a generic pattern-match FSM.

## Interface
- PATTERN_W, 4: pattern length in bits, legal range 2..16.
- PATTERN, 4'b1011: pattern to detect. Bit PATTERN_W-1 is the first bit received.
- OVERLAP, 1: 1 = a match may reuse the tail of the previous match; 0 = matching restarts from empty after each match.
- MEALY, 1: 1 = combinational Mealy output; 0 = registered Moore output.
- COUNT_W, 8: width of the match counter.

- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous clear of the detector state and the counter.
- din_valid, input, 1: din is sampled only when this is high.
- din, input, 1: serial data bit.
- dout, output, 1: match flag.
- match_count, output, COUNT_W: number of matches, saturating.
- state_o, output, $clog2(PATTERN_W+1): current prefix-match length (debug).

## Operation
- State S0..S(PATTERN_W-1) = number of pattern bits currently matched. Reset state is S0.
- On an accepted bit (din_valid=1, clr=0):
  - din equals the expected bit PATTERN[PATTERN_W-1-s] and s < PATTERN_W-1: go to s+1.
  - din equals the expected bit and s = PATTERN_W-1: this is a match.
  - Otherwise go to the longest prefix of PATTERN that is a proper suffix of (the matched prefix followed by din). This uses KMP fallback, not a restart to S0.
- State after a match:
  - OVERLAP=1: go to fail(PATTERN_W), the longest proper prefix of PATTERN that is also a suffix of PATTERN.
  - OVERLAP=0: go to S0.
- Transition table next[s][b] and the fail values are computed at elaboration. No run-time arithmetic.
- din_valid=0: state holds and no match can occur.
- clr=1: state goes to S0 and match_count goes to 0. clr overrides any same-cycle match: the match is not counted and Mealy dout is held low.
- match_count increments by 1 per match and holds at 2^COUNT_W-1.
- Reset (rst=0, at any time, including mid-pattern): state S0, dout 0, match_count 0, internal Moore flag 0.

## Timing
- MEALY=1: dout = din_valid & ~clr & (s==PATTERN_W-1) & (din==PATTERN[0]). It is combinational and asserts in the same cycle as the final bit.
- MEALY=0: dout is registered. It is high for exactly one cycle, the cycle after the final bit is accepted, and is cleared on the next edge regardless of din_valid.
- match_count updates on the same edge that consumes the final bit. It is visible one cycle after the Mealy dout pulse and in the same cycle as the Moore dout pulse.
- Throughput: one bit per clock. A match is possible on every accepted bit only when the pattern's fail value is PATTERN_W-1, e.g. 1111 with OVERLAP=1.
- Bubbles (din_valid low) may occur anywhere inside a pattern without breaking the match.

## Structure
- Package fsm_pkg holds:
  - the elaboration-time functions fail_len(pattern, width) and next_state(pattern, width, s, b);
  - localparams MODE_MEALY and MODE_MOORE.
- Three-process FSM: state register, next-state/match logic, output logic.
- One sub-module, sat_counter (parameter WIDTH; ports clk, rst, clr, inc, count), instantiated for match_count.

## Test plan
- Reset: hold rst=0 for 400 ns with din toggling -> dout=0, match_count=0, state_o=0 throughout. Release rst -> detection starts from S0.
- Pattern 1011 with OVERLAP=1, MEALY=1, stream 1011011 -> dout high in the same cycle as bit 4 and bit 7; match_count=2.
- Same stream with OVERLAP=0 -> single match at bit 4; match_count=1; final state_o=1.
- MEALY=0, stream 1011 -> dout pulses once, in the cycle after bit 4 is accepted, for exactly one cycle.
- Stream 10, then din_valid=0 for 3 cycles, then 11 -> one match; state_o holds at 2 during the bubble.
- Saturation and clear:
  - COUNT_W=2, feed 5 matches -> match_count stops at 3.
  - Assert clr in the cycle of a final bit -> no dout, match_count=0, state_o=0.
  - Pulse rst mid-pattern (after 101) -> state_o=0 immediately, without waiting for a clock edge.
